frame_reader: RTL

//  Read-side counterpart of the frame-buffer write arbiter: scans the frame buffer from word 0 to mem_depth-1.

---
 rtl/frame_reader_pkg.sv | 20 ++
 rtl/frame_reader_fifo.sv | 70 +++++++
 rtl/frame_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/frame_reader_pkg.sv
// rtl/frame_reader_pkg.sv - shared FSM encoding and pixel-packing helpers for frame_reader
package frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Pixels carried by one frame-buffer word.
  function automatic int calc_ppw(input int mem_width, input int pix_width);
    return mem_width / pix_width;
  endfunction

  // Width of an index over n items, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// rtl/frame_reader_fifo.sv - 2-entry word buffer between frame-buffer reads and pixel unpack
module frame_reader_fifo #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [width-1:0] head
);

  logic [width-1:0] mem0_q, mem0_d;
  logic [width-1:0] mem1_q, mem1_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  // Next-state: clear wins; otherwise write at wr_ptr, advance rd_ptr on pop.
  // When full, push+pop writes over the slot being popped, which is consumed at the same edge.
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      mem0_d   = '0;
      mem1_d   = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) mem1_d = push_data;
        else          mem0_d = push_data;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = rd_ptr_q ? mem1_q : mem0_q;

  // The issue rule upstream guarantees a full buffer is never pushed without a pop.
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
                                  !(push && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - scans the frame buffer once per start and streams its pixels LSB-first
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int mem_width      = 32,
  parameter int mem_depth      = 32,
  parameter int mem_addr_width = $clog2(mem_depth),
  parameter int pix_width      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      frame_rd_en,
  output logic [mem_addr_width-1:0] frame_rd_addr,
  input  logic [mem_width-1:0]      frame_rd_data,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [pix_width-1:0]      pix_data,
  output logic                      pix_last
);

  localparam int ppw = calc_ppw(mem_width, pix_width);
  localparam int kw  = idx_width(ppw);
  localparam int cw  = mem_addr_width + 1;
  localparam logic [cw-1:0] depth_c     = cw'(mem_depth);
  localparam logic [cw-1:0] last_word_c = cw'(mem_depth - 1);
  localparam logic [kw-1:0] k_last_c    = kw'(ppw - 1);

  state_e              state_q, state_d;
  logic [cw-1:0]       issue_cnt_q, issue_cnt_d;
  logic                inflight_q, inflight_d;
  logic [kw-1:0]       k_q, k_d;
  logic [cw-1:0]       word_idx_q, word_idx_d;

  logic [1:0]          fifo_count;
  logic [mem_width-1:0] fifo_head;
  logic                fifo_pop;
  logic                fifo_clr;
  logic                handshake;
  logic [2:0]          pending;

  frame_reader_fifo #(.width(mem_width)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fifo_clr),
    .push      (inflight_q),
    .push_data (frame_rd_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Unpack view of the head word and the handshake it implies.
  always_comb begin
    pix_valid = (fifo_count != 2'd0);
    pix_data  = fifo_head[k_q*pix_width +: pix_width];
    pix_last  = pix_valid && (word_idx_q == last_word_c) && (k_q == k_last_c);
    handshake = pix_valid && pix_ready;
    fifo_pop  = handshake && (k_q == k_last_c);
    // Words buffered or in flight once this cycle's pop retires; counting the pop keeps
    // one-pixel-per-cycle flow when a word holds a single pixel, and still never exceeds 2.
    pending   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, fifo_pop};
  end

  // FSM next state, read issue and unpack index.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    inflight_d  = 1'b0;
    k_d         = k_q;
    word_idx_d  = word_idx_q;
    fifo_clr    = 1'b0;
    frame_rd_en = 1'b0;

    if (handshake) begin
      k_d = (k_q == k_last_c) ? '0 : k_q + kw'(1);
      if (fifo_pop) word_idx_d = word_idx_q + cw'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          issue_cnt_d = '0;
          k_d         = '0;
          word_idx_d  = '0;
          fifo_clr    = 1'b1;
        end
      end
      ST_FETCH: begin
        if ((issue_cnt_q < depth_c) && (pending < 3'd2)) begin
          frame_rd_en = 1'b1;
          issue_cnt_d = issue_cnt_q + cw'(1);
          inflight_d  = 1'b1;
          if (issue_cnt_q == last_word_c) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (handshake && pix_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and index registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      inflight_q  <= 1'b0;
      k_q         <= '0;
      word_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      inflight_q  <= inflight_d;
      k_q         <= k_d;
      word_idx_q  <= word_idx_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign frame_rd_addr = issue_cnt_q[mem_addr_width-1:0];

endmodule
